// File: rtl/reorder_buffer_if.sv
// Handshake bundle between dispatch, the FU writeback ports and the reorder buffer.
// slave: the ROB side; master: the dispatch/writeback/commit consumer side.
interface reorder_buffer_if #(
    parameter int TAG_W  = 6,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
);
    logic              disp_valid;
    logic [PREG_W-1:0] disp_rd;
    logic [PREG_W-1:0] disp_rd_old;
    logic              disp_ready;
    logic [TAG_W-1:0]  disp_tag;

    logic [2:0]        wb_valid;
    logic [TAG_W-1:0]  wb_tag0;
    logic [TAG_W-1:0]  wb_tag1;
    logic [TAG_W-1:0]  wb_tag2;
    logic [DATA_W-1:0] wb_data0;
    logic [DATA_W-1:0] wb_data1;
    logic [DATA_W-1:0] wb_data2;

    logic [1:0]        commit_valid;
    logic [PREG_W-1:0] commit_rd0;
    logic [PREG_W-1:0] commit_rd1;
    logic [PREG_W-1:0] commit_rd_old0;
    logic [PREG_W-1:0] commit_rd_old1;
    logic [DATA_W-1:0] commit_data0;
    logic [DATA_W-1:0] commit_data1;
    logic [TAG_W:0]    rob_count;
    logic              rob_empty;

    modport master (
        output disp_valid, disp_rd, disp_rd_old,
        output wb_valid, wb_tag0, wb_tag1, wb_tag2,
        output wb_data0, wb_data1, wb_data2,
        input  disp_ready, disp_tag,
        input  commit_valid, commit_rd0, commit_rd1,
        input  commit_rd_old0, commit_rd_old1,
        input  commit_data0, commit_data1,
        input  rob_count, rob_empty
    );

    modport slave (
        input  disp_valid, disp_rd, disp_rd_old,
        input  wb_valid, wb_tag0, wb_tag1, wb_tag2,
        input  wb_data0, wb_data1, wb_data2,
        output disp_ready, disp_tag,
        output commit_valid, commit_rd0, commit_rd1,
        output commit_rd_old0, commit_rd_old1,
        output commit_data0, commit_data1,
        output rob_count, rob_empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates a tag per dispatch, marks entries done on
// writeback (3 ports, lowest index wins), commits up to two oldest done entries per cycle.
// Ports: clk, rst (async, active-high), bus (reorder_buffer_if.slave: dispatch,
// writeback and commit groups), flush (only when ROB_FLUSH_EN is defined).
module reorder_buffer #(
    parameter int ROB_DEPTH = 64,
    parameter int TAG_W     = 6,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
) (
    input logic             clk,
    input logic             rst,
`ifdef ROB_FLUSH_EN
    input logic             flush,
`endif
    reorder_buffer_if.slave bus
);

    localparam int PTR_W = TAG_W + 1;

`ifndef ROB_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  occ;
    logic [PTR_W-1:0]  cnt;
    logic [PTR_W-1:0]  cnt_nxt;

    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] done;
    logic [PREG_W-1:0]    rd_mem     [ROB_DEPTH];
    logic [PREG_W-1:0]    rd_old_mem [ROB_DEPTH];
    logic [DATA_W-1:0]    data_mem   [ROB_DEPTH];

    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  head_nxt_idx;
    logic [TAG_W-1:0]  tail_idx;

    logic [TAG_W-1:0]  wb_tag  [3];
    logic [DATA_W-1:0] wb_data [3];
    logic [2:0]        wb_hit;

    logic disp_fire;
    logic fire0;
    logic fire1;

    assign head_idx     = head[TAG_W-1:0];
    assign head_nxt_idx = head_idx + 1'b1;
    assign tail_idx     = tail[TAG_W-1:0];

    assign wb_tag[0]  = bus.wb_tag0;
    assign wb_tag[1]  = bus.wb_tag1;
    assign wb_tag[2]  = bus.wb_tag2;
    assign wb_data[0] = bus.wb_data0;
    assign wb_data[1] = bus.wb_data1;
    assign wb_data[2] = bus.wb_data2;

    assign occ            = tail - head;
    assign bus.disp_ready = occ < PTR_W'(ROB_DEPTH);
    assign bus.disp_tag   = tail_idx;
    assign bus.rob_count  = cnt;

    // Flush overrides every other action on its edge.
    assign disp_fire = bus.disp_valid & bus.disp_ready & ~flush;
    assign fire0     = valid[head_idx] & done[head_idx] & ~flush;
    assign fire1     = fire0 & valid[head_nxt_idx] & done[head_nxt_idx];

    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < 3; i++) begin
            wb_hit[i] = bus.wb_valid[i] & valid[wb_tag[i]] & ~flush;
        end
    end

    assign cnt_nxt = cnt + PTR_W'(disp_fire) - PTR_W'(fire0) - PTR_W'(fire1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid              <= '0;
            done               <= '0;
            head               <= '0;
            tail               <= '0;
            cnt                <= '0;
            bus.rob_empty      <= 1'b1;
            bus.commit_valid   <= '0;
            bus.commit_rd0     <= '0;
            bus.commit_rd1     <= '0;
            bus.commit_rd_old0 <= '0;
            bus.commit_rd_old1 <= '0;
            bus.commit_data0   <= '0;
            bus.commit_data1   <= '0;
        end else begin
            bus.commit_valid <= {fire1, fire0};
            if (flush) begin
                valid         <= '0;
                done          <= '0;
                head          <= tail;
                cnt           <= '0;
                bus.rob_empty <= 1'b1;
            end else begin
                if (fire0) begin
                    valid[head_idx]    <= 1'b0;
                    done[head_idx]     <= 1'b0;
                    bus.commit_rd0     <= rd_mem[head_idx];
                    bus.commit_rd_old0 <= rd_old_mem[head_idx];
                    bus.commit_data0   <= data_mem[head_idx];
                end
                if (fire1) begin
                    valid[head_nxt_idx] <= 1'b0;
                    done[head_nxt_idx]  <= 1'b0;
                    bus.commit_rd1      <= rd_mem[head_nxt_idx];
                    bus.commit_rd_old1  <= rd_old_mem[head_nxt_idx];
                    bus.commit_data1    <= data_mem[head_nxt_idx];
                end
                for (int i = 0; i < 3; i++) begin
                    if (wb_hit[i]) done[wb_tag[i]] <= 1'b1;
                end
                // The tail slot is never valid, so it cannot collide with a writeback.
                if (disp_fire) begin
                    valid[tail_idx] <= 1'b1;
                    done[tail_idx]  <= 1'b0;
                end
                head          <= head + PTR_W'(fire0) + PTR_W'(fire1);
                tail          <= tail + PTR_W'(disp_fire);
                cnt           <= cnt_nxt;
                bus.rob_empty <= (cnt_nxt == '0);
            end
        end
    end

    // Payload needs no reset: it is only read behind valid/done.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            rd_mem[tail_idx]     <= bus.disp_rd;
            rd_old_mem[tail_idx] <= bus.disp_rd_old;
        end
        // Descending order so the lowest port's write is the one that sticks.
        for (int i = 2; i >= 0; i--) begin
            if (wb_hit[i]) data_mem[wb_tag[i]] <= wb_data[i];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer.
// Dispatch pushes the tag to an in-order queue; the commit monitor pops and compares.
module tb_reorder_buffer;

    logic clk;
    logic rst;
`ifdef ROB_FLUSH_EN
    logic flush;
`endif

    reorder_buffer_if #(.TAG_W(6), .PREG_W(6), .DATA_W(32)) bus ();

    reorder_buffer dut (
        .clk  (clk),
        .rst  (rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_commits = 0;

    logic [5:0]  m_tail;
    logic [5:0]  m_rd     [64];
    logic [5:0]  m_rd_old [64];
    logic [31:0] m_data   [64];
    bit          m_valid  [64];
    logic [5:0]  sbq [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Commit monitor: each set slot must match the oldest outstanding dispatch.
    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                if (bus.commit_valid[s]) begin
                    check("commit_sb_nonempty", 64'(sbq.size() > 0), 64'd1);
                    if (sbq.size() > 0) begin
                        logic [5:0] t;
                        t = sbq.pop_front();
                        m_valid[t] = 1'b0;
                        m_commits++;
                        if (s == 0) begin
                            check("commit_rd0", 64'(bus.commit_rd0), 64'(m_rd[t]));
                            check("commit_rd_old0", 64'(bus.commit_rd_old0), 64'(m_rd_old[t]));
                            check("commit_data0", 64'(bus.commit_data0), 64'(m_data[t]));
                        end else begin
                            check("commit_rd1", 64'(bus.commit_rd1), 64'(m_rd[t]));
                            check("commit_rd_old1", 64'(bus.commit_rd_old1), 64'(m_rd_old[t]));
                            check("commit_data1", 64'(bus.commit_data1), 64'(m_data[t]));
                        end
                    end
                end
            end
        end
    end

    task automatic model_clear();
        sbq.delete();
        m_tail = '0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 model_clear();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] rd, input logic [5:0] rd_old, input bit acc);
        bus.disp_valid  = 1'b1;
        bus.disp_rd     = rd;
        bus.disp_rd_old = rd_old;
        #1;
        check("disp_ready", 64'(bus.disp_ready), 64'(acc));
        if (acc) begin
            check("disp_tag", 64'(bus.disp_tag), 64'(m_tail));
            m_rd[m_tail]     = rd;
            m_rd_old[m_tail] = rd_old;
            m_data[m_tail]   = 'x;
            m_valid[m_tail]  = 1'b1;
            sbq.push_back(m_tail);
            m_tail++;
        end
        @(negedge clk);
        bus.disp_valid = 1'b0;
        #1;
    endtask

    task automatic wb(input logic [2:0] v,
                      input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [5:0]  t [3];
        logic [31:0] d [3];
        bit          seen [64];
        t[0] = t0; t[1] = t1; t[2] = t2;
        d[0] = d0; d[1] = d1; d[2] = d2;
        bus.wb_valid = v;
        bus.wb_tag0  = t0; bus.wb_tag1  = t1; bus.wb_tag2  = t2;
        bus.wb_data0 = d0; bus.wb_data1 = d1; bus.wb_data2 = d2;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (v[i] && m_valid[t[i]] && !seen[t[i]]) begin
                m_data[t[i]] = d[i];
                seen[t[i]]   = 1'b1;
            end
        end
        @(negedge clk);
        bus.wb_valid = '0;
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        bus.disp_valid = 1'b0; bus.disp_rd = '0; bus.disp_rd_old = '0;
        bus.wb_valid = '0;
        bus.wb_tag0 = '0; bus.wb_tag1 = '0; bus.wb_tag2 = '0;
        bus.wb_data0 = '0; bus.wb_data1 = '0; bus.wb_data2 = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state and a single round trip.
        check("rst_count", 64'(bus.rob_count), 64'd0);
        check("rst_empty", 64'(bus.rob_empty), 64'd1);
        check("rst_cv", 64'(bus.commit_valid), 64'd0);
        check("rst_rd0", 64'(bus.commit_rd0), 64'd0);
        check("rst_data1", 64'(bus.commit_data1), 64'd0);
        dispatch(6'd5, 6'd1, 1'b1);
        check("t1_count", 64'(bus.rob_count), 64'd1);
        check("t1_empty", 64'(bus.rob_empty), 64'd0);
        wb(3'b001, 6'd0, 6'd0, 6'd0, 32'hDEAD, 32'h0, 32'h0);
        check("t1_cv_wb_edge", 64'(bus.commit_valid), 64'd0);
        idle(1);
        check("t1_cv", 64'(bus.commit_valid), 64'b01);
        check("t1_rd0", 64'(bus.commit_rd0), 64'd5);
        check("t1_empty_after", 64'(bus.rob_empty), 64'd1);
        idle(1);
        check("t1_cv_pulse", 64'(bus.commit_valid), 64'd0);
        check("t1_data_hold", 64'(bus.commit_data0), 64'hDEAD);

        // Out-of-order completion, in-order dual commit.
        do_reset();
        dispatch(6'd10, 6'd20, 1'b1);
        dispatch(6'd11, 6'd21, 1'b1);
        dispatch(6'd12, 6'd22, 1'b1);
        wb(3'b001, 6'd2, 6'd0, 6'd0, 32'h2222, 32'h0, 32'h0);
        check("t2_cv_a", 64'(bus.commit_valid), 64'd0);
        wb(3'b010, 6'd0, 6'd1, 6'd0, 32'h0, 32'h1111, 32'h0);
        check("t2_cv_b", 64'(bus.commit_valid), 64'd0);
        wb(3'b100, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0F0F);
        check("t2_cv_c", 64'(bus.commit_valid), 64'd0);
        idle(1);
        check("t2_cv_dual", 64'(bus.commit_valid), 64'b11);
        check("t2_count1", 64'(bus.rob_count), 64'd1);
        idle(1);
        check("t2_cv_last", 64'(bus.commit_valid), 64'b01);
        check("t2_count0", 64'(bus.rob_count), 64'd0);
        check("t2_empty", 64'(bus.rob_empty), 64'd1);

        // Full buffer, dropped dispatch, wrap of the tag.
        do_reset();
        for (int i = 0; i < 64; i++) dispatch(6'(i), 6'(63 - i), 1'b1);
        check("t3_count_full", 64'(bus.rob_count), 64'd64);
        dispatch(6'd33, 6'd44, 1'b0);
        check("t3_count_drop", 64'(bus.rob_count), 64'd64);
        wb(3'b001, 6'd0, 6'd0, 6'd0, 32'h1234, 32'h0, 32'h0);
        check("t3_ready_still0", 64'(bus.disp_ready), 64'd0);
        idle(1);
        check("t3_cv", 64'(bus.commit_valid), 64'b01);
        check("t3_count63", 64'(bus.rob_count), 64'd63);
        dispatch(6'd7, 6'd7, 1'b1);
        check("t3_count_refill", 64'(bus.rob_count), 64'd64);

        // Same-tag writeback priority and writeback to an unallocated tag.
        do_reset();
        base = m_commits;
        for (int i = 0; i < 8; i++) dispatch(6'(i + 1), 6'(i + 40), 1'b1);
        wb(3'b011, 6'd7, 6'd7, 6'd0, 32'h11, 32'h22, 32'h0);
        wb(3'b001, 6'd9, 6'd0, 6'd0, 32'h99, 32'h0, 32'h0);
        check("t4_cv_none", 64'(bus.commit_valid), 64'd0);
        wb(3'b111, 6'd0, 6'd1, 6'd2, 32'hA0, 32'hA1, 32'hA2);
        wb(3'b111, 6'd3, 6'd4, 6'd5, 32'hA3, 32'hA4, 32'hA5);
        wb(3'b001, 6'd6, 6'd0, 6'd0, 32'hA6, 32'h0, 32'h0);
        idle(4);
        check("t4_commits", 64'(m_commits - base), 64'd8);
        check("t4_count", 64'(bus.rob_count), 64'd0);

        // Asynchronous reset with in-flight entries.
        do_reset();
        for (int i = 0; i < 10; i++) dispatch(6'(i), 6'(i), 1'b1);
        wb(3'b111, 6'd3, 6'd4, 6'd5, 32'h3, 32'h4, 32'h5);
        check("t5_cv_pre", 64'(bus.commit_valid), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("t5_cv", 64'(bus.commit_valid), 64'd0);
        check("t5_count", 64'(bus.rob_count), 64'd0);
        check("t5_empty", 64'(bus.rob_empty), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 model_clear();
        idle(3);
        dispatch(6'd9, 6'd9, 1'b1);
        wb(3'b001, 6'd0, 6'd0, 6'd0, 32'h5A5A, 32'h0, 32'h0);
        idle(2);
        check("t5_drain", 64'(bus.rob_count), 64'd0);

`ifdef ROB_FLUSH_EN
        // Flush beats a concurrent dispatch and writeback.
        do_reset();
        for (int i = 0; i < 8; i++) dispatch(6'(i), 6'(i), 1'b1);
        flush = 1'b1;
        bus.disp_valid = 1'b1; bus.disp_rd = 6'd3; bus.disp_rd_old = 6'd4;
        bus.wb_valid = 3'b001; bus.wb_tag0 = 6'd0; bus.wb_data0 = 32'hBEEF;
        @(negedge clk);
        flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.wb_valid = '0;
        #1;
        sbq.delete();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        check("t6_count", 64'(bus.rob_count), 64'd0);
        check("t6_cv", 64'(bus.commit_valid), 64'd0);
        check("t6_empty", 64'(bus.rob_empty), 64'd1);
        idle(2);
        check("t6_cv_later", 64'(bus.commit_valid), 64'd0);
        dispatch(6'd1, 6'd2, 1'b1);
        wb(3'b001, 6'd8, 6'd0, 6'd0, 32'hC0DE, 32'h0, 32'h0);
        idle(2);
        check("t6_count_after", 64'(bus.rob_count), 64'd0);
`endif

        idle(2);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
